// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO pointer/flag controller and its storage array.
package fifo_pkg;

  localparam int FIFO_DEPTH_DEFAULT = 8;

  // Pointer carries one extra wrap bit above the word index.
  typedef logic [$clog2(FIFO_DEPTH_DEFAULT):0] ptr_t;

  // Increment an (aw+1)-bit pointer. The index wraps DEPTH-1 -> 0 and the wrap bit toggles.
  function automatic logic [31:0] ptr_next(input logic [31:0] p, input int aw);
    logic [31:0] mask;
    mask = (32'd1 << (aw + 1)) - 32'd1;
    return (p + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// Request/status bundle between the FIFO pointer controller and its user.
// The almost_full/almost_empty pair exists only when FIFO_ALMOST_FLAGS_EN is defined.
interface fifo_ptr_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_req;
  logic              rd_req;
  logic [DEPTH-1:0]  wr_en_vec;
  logic [ADDR_W-1:0] rd_addr;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic              almost_full;
  logic              almost_empty;
`endif

  modport master (
    output wr_req,
    output rd_req,
    input  wr_en_vec,
    input  rd_addr,
    input  full,
    input  empty,
    input  count
`ifdef FIFO_ALMOST_FLAGS_EN
    , input almost_full
    , input almost_empty
`endif
  );

  modport slave (
    input  wr_req,
    input  rd_req,
    output wr_en_vec,
    output rd_addr,
    output full,
    output empty,
    output count
`ifdef FIFO_ALMOST_FLAGS_EN
    , output almost_full
    , output almost_empty
`endif
  );

endinterface

// File: rtl/fifo_onehot_dec.sv
// Binary index to one-hot decoder; all-zero when the enable is low.
module fifo_onehot_dec
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] i_idx,
  input  logic              i_en,
  output logic [DEPTH-1:0]  o_vec
);

  always_comb begin
    o_vec = '0;
    if (i_en) o_vec[i_idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer and flag controller: one-hot word write enables, show-ahead read address,
// registered full/empty/count. Define FIFO_ALMOST_FLAGS_EN for almost_full/almost_empty.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
`ifdef FIFO_ALMOST_FLAGS_EN
  , parameter int AF_LEVEL = DEPTH - 2
  , parameter int AE_LEVEL = 1
`endif
) (
  input logic            clk,
  input logic            rst_n,
  fifo_ptr_ctrl_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  typedef logic [ADDR_W:0] lptr_t;
  localparam lptr_t ONE = {{ADDR_W{1'b0}}, 1'b1};

  lptr_t            r_wr_ptr;
  lptr_t            r_rd_ptr;
  lptr_t            r_count;
  logic             r_full;
  logic             r_empty;

  lptr_t            w_wr_ptr_nxt;
  lptr_t            w_rd_ptr_nxt;
  lptr_t            w_count_nxt;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_full_nxt;
  logic             w_empty_nxt;
  logic [DEPTH-1:0] w_wr_en_vec;

  // rst_n gates the write accept so no storage enable can pulse while reset is held.
  assign w_wr_acc = bus.wr_req & ~r_full & rst_n;
  assign w_rd_acc = bus.rd_req & ~r_empty;

  assign w_wr_ptr_nxt = w_wr_acc ? lptr_t'(ptr_next(32'(r_wr_ptr), ADDR_W)) : r_wr_ptr;
  assign w_rd_ptr_nxt = w_rd_acc ? lptr_t'(ptr_next(32'(r_rd_ptr), ADDR_W)) : r_rd_ptr;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc)      w_count_nxt = r_count + ONE;
    else if (!w_wr_acc && w_rd_acc) w_count_nxt = r_count - ONE;
  end

  assign w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
  assign w_full_nxt  = (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]) &&
                       (w_wr_ptr_nxt[ADDR_W] != w_rd_ptr_nxt[ADDR_W]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_full   <= w_full_nxt;
      r_empty  <= w_empty_nxt;
    end
  end

  fifo_onehot_dec #(
    .DEPTH (DEPTH)
  ) u_wr_dec (
    .i_idx (r_wr_ptr[ADDR_W-1:0]),
    .i_en  (w_wr_acc),
    .o_vec (w_wr_en_vec)
  );

  assign bus.wr_en_vec = w_wr_en_vec;
  assign bus.rd_addr   = r_rd_ptr[ADDR_W-1:0];
  assign bus.full      = r_full;
  assign bus.empty     = r_empty;
  assign bus.count     = r_count;

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam lptr_t AF_L = lptr_t'(AF_LEVEL);
  localparam lptr_t AE_L = lptr_t'(AE_LEVEL);

  logic r_almost_full;
  logic r_almost_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_full  <= (w_count_nxt >= AF_L);
      r_almost_empty <= (w_count_nxt <= AE_L);
    end
  end

  assign bus.almost_full  = r_almost_full;
  assign bus.almost_empty = r_almost_empty;
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl (DEPTH=8): directed vectors queue expected outputs,
// a monitor pops and compares them each cycle away from the active edge.
module tb_fifo_ptr_ctrl;
  import fifo_pkg::*;

  logic clk;
  logic rst_n;

  fifo_ptr_ctrl_if #(.DEPTH(8)) bus ();

  fifo_ptr_ctrl #(.DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [7:0] wen;
    int         ra;
    logic       fl;
    logic       em;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string n, input logic [7:0] wen, input int ra,
                      input logic fl, input logic em, input int cnt);
    exp_t x;
    x.name = n; x.wen = wen; x.ra = ra; x.fl = fl; x.em = em; x.cnt = cnt;
    sb.push_back(x);
  endtask

  task automatic step(input string n, input logic wr, input logic rd, input logic [7:0] wen,
                      input int ra, input logic fl, input logic em, input int cnt);
    @(negedge clk);
    bus.wr_req = wr;
    bus.rd_req = rd;
    push(n, wen, ra, fl, em, cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare every queued expectation against the settled DUT outputs.
  initial begin : monitor
    exp_t x;
    logic ok;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() != 0) begin
        x = sb.pop_front();
        ok = (bus.wr_en_vec === x.wen) && (int'(bus.rd_addr) == x.ra) &&
             (bus.full === x.fl) && (bus.empty === x.em) && (int'(bus.count) == x.cnt) &&
             !(bus.full && bus.empty);
`ifdef FIFO_ALMOST_FLAGS_EN
        ok = ok && (bus.almost_full === (x.cnt >= 6)) && (bus.almost_empty === (x.cnt <= 1));
`endif
        total++;
        if (!ok) begin
          bad++;
          $display("FAIL %s: got wen=%h ra=%0d full=%b empty=%b cnt=%0d, expected wen=%h ra=%0d full=%b empty=%b cnt=%0d",
                   x.name, bus.wr_en_vec, bus.rd_addr, bus.full, bus.empty, bus.count,
                   x.wen, x.ra, x.fl, x.em, x.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n      = 1'b0;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) step("idle", 0, 0, 8'h00, 0, 0, 1, 0);

    // Fill to full, then a dropped write.
    for (int i = 0; i < 8; i++) step("fill", 1, 0, 8'(1 << i), 0, 0, (i == 0), i);
    step("wr_when_full", 1, 0, 8'h00, 0, 1, 0, 8);
    step("full_hold", 0, 0, 8'h00, 0, 1, 0, 8);

    // Drain, then a dropped read.
    for (int i = 0; i < 8; i++) step("drain", 0, 1, 8'h00, i, (i == 0), 0, 8 - i);
    step("rd_when_empty", 0, 1, 8'h00, 0, 0, 1, 0);
    step("empty_hold", 0, 0, 8'h00, 0, 0, 1, 0);

    // Wrap: write 6, read 6, write 4.
    for (int i = 0; i < 6; i++) step("wrap_wr6", 1, 0, 8'(1 << i), 0, 0, (i == 0), i);
    for (int i = 0; i < 6; i++) step("wrap_rd6", 0, 1, 8'h00, i, 0, 0, 6 - i);
    step("wrap_wr4_0", 1, 0, 8'h40, 6, 0, 1, 0);
    step("wrap_wr4_1", 1, 0, 8'h80, 6, 0, 0, 1);
    step("wrap_wr4_2", 1, 0, 8'h01, 6, 0, 0, 2);
    step("wrap_wr4_3", 1, 0, 8'h02, 6, 0, 0, 3);
    step("wrap_idle", 0, 0, 8'h00, 6, 0, 0, 4);

    // Top up to full, then simultaneous write+read while full.
    for (int i = 0; i < 4; i++) step("topup", 1, 0, 8'(4 << i), 6, 0, 0, 4 + i);
    step("both_when_full", 1, 1, 8'h00, 6, 1, 0, 8);
    step("after_both_full", 0, 0, 8'h00, 7, 0, 0, 7);

    // Simultaneous write+read while empty, from a fresh reset.
    do_reset();
    step("both_when_empty", 1, 1, 8'h01, 0, 0, 1, 0);
    step("after_both_empty", 0, 0, 8'h00, 0, 0, 0, 1);

    // Build to 5 words, then assert reset between clock edges with a write pending.
    for (int i = 0; i < 4; i++) step("pre_rst_wr", 1, 0, 8'(2 << i), 0, 0, 0, 1 + i);
    step("pre_rst", 0, 0, 8'h00, 0, 0, 0, 5);
    @(negedge clk);
    bus.wr_req = 1'b1;
    #1;
    rst_n = 1'b0;
    push("rst_async", 8'h00, 0, 0, 1, 0);
    step("rst_hold", 1, 0, 8'h00, 0, 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.wr_req = 1'b0;
    push("rst_release", 8'h00, 0, 0, 1, 0);
    step("post_rst_wr", 1, 0, 8'h01, 0, 0, 1, 0);
    step("post_rst_idle", 0, 0, 8'h00, 0, 0, 0, 1);

    @(negedge clk);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    #4;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
